ofs_plat_axi_mem_if_credit_tx: RTL and testbench
================================================

// Module: ofs_plat_axi_mem_if_credit_tx
// PURPOSE
//  Credit-based transmitter for a single AXI channel. Single clock domain.
//  - Upstream: standard AXI valid/ready.
//  - Downstream: valid-only link into a receiver FIFO of N_CREDITS entries.
//  - Receiver returns credits as it dequeues. Never stalls tx on ready, so
//    deep pipeline registers can be placed between tx and receiver.
//  - Sits at the sending end of long-haul or clock-crossing channels in the
//    AXI memory shims.
// PARAMETERS
//  DATA_WIDTH     1   payload bits (packed AXI channel struct)
//  N_CREDITS      16  receiver buffer depth = initial credit count; >=1
//  TX_REG_STAGES  1   register stages on tx_valid/tx_data; >=1
//  CW             $clog2(N_CREDITS+1)  derived; credit counter/port width
// PORTS
//  clk                input   1     clock
//  reset_n            input   1     async active-low reset
//  ready_in           output  1     upstream ready
//  valid_in           input   1     upstream valid
//  data_in            input   DW    upstream payload
//  tx_valid           output  1     downstream beat valid (no ready)
//  tx_data            output  DW    downstream payload
//  credit_return      input   CW    credits returned this cycle (0..N_CREDITS)
//  credits_avail      output  CW    current credit count
//  idle               output  1     nothing buffered/in flight, all credits home
//  credit_overflow_err output 1     sticky: returned credits exceeded N_CREDITS
// BEHAVIOUR
//  Reset:
//  - reset_n low asynchronously clears all state:
//    tx_valid=0, ready_in=0, credits_avail=N_CREDITS, credit_overflow_err=0.
//  - Skid buffer and output pipeline are emptied. Data regs need no reset.
//  - Reset mid-stream discards every buffered or in-flight beat.
//  - idle=1 from the first cycle after reset release.
//  Upstream:
//  - 2-entry FIFO (skid). ready_in = registered notFull of the skid.
//  - Beat accepted when valid_in && ready_in.
//  - ready_in may fall only as a result of a prior accept; never combinational
//    from credits.
//  Launch:
//  - launch = skid notEmpty && (credit_cnt != 0). Uses the registered count only.
//  - On launch: skid entry dequeued, enters TX_REG_STAGES pipeline.
//  Credit counter:
//  - cnt_next = cnt - launch + credit_return, computed CW+1 bits wide.
//  - If cnt_next > N_CREDITS: cnt saturates to N_CREDITS and
//    credit_overflow_err sets (sticky until reset).
//  - Launch and return in the same cycle: both apply. At cnt==1 with
//    return=1, cnt stays 1.
//  - A return arriving at cnt==0 enables a launch the following cycle,
//    not the same cycle.
//  Timing and ordering:
//  - Latency: beat accepted in cycle t with credits available gives tx_valid
//    in cycle t+1+TX_REG_STAGES.
//  - Throughput: 1 beat/cycle while credits remain.
//  - Order is strictly preserved.
//  - tx_valid is a 1-cycle pulse per beat. Never duplicated; never dropped
//    except by reset.
//  idle:
//  - idle = skid empty && no valid in pipeline && cnt==N_CREDITS.
//  - Registered.
//  Credit invariant (no overflow case):
//  - credits_avail + beats in flight/queued at receiver == N_CREDITS.
// TESTING
//  1. Release reset, no traffic -> cycle 1: ready_in=1, credits_avail=16,
//     idle=1, tx_valid=0.
//  2. N_CREDITS=16, 20 back-to-back beats (data 0..19), no returns ->
//     - exactly 16 tx_valid pulses, data 0..15 in order
//     - credits_avail=0
//     - beats 16,17 held in skid; ready_in=0; beats 18,19 held upstream
//  3. From (2), credit_return=3 in one cycle -> beats 16,17,18 emerge on
//     consecutive cycles; credits_avail ends at 0.
//  4. cnt=1, launch and credit_return=1 in same cycle -> credits_avail stays 1;
//     next beat launches the following cycle.
//  5. cnt=16, credit_return=1 -> credits_avail stays 16; credit_overflow_err=1
//     and remains 1 until reset.
//  6. Assert reset_n=0 mid-stream with 5 beats in flight -> tx_valid=0
//     immediately (async); after release credits_avail=16, no stale beats
//     emitted.

Source files
------------

// File: rtl/ofs_plat_axi_mem_if_credit_tx.sv
// Credit-based transmitter for one AXI channel: 2-entry skid buffer, credit
// counter gating launches, and a valid-only output pipeline toward a receiver FIFO.
module ofs_plat_axi_mem_if_credit_tx #(
   parameter int unsigned DATA_WIDTH    = 1,
   parameter int unsigned N_CREDITS     = 16,
   parameter int unsigned TX_REG_STAGES = 1,
   parameter int unsigned CW            = $clog2(N_CREDITS + 1)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   output logic                  ready_in,
   input  logic                  valid_in,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic                  tx_valid,
   output logic [DATA_WIDTH-1:0] tx_data,
   input  logic [CW-1:0]         credit_return,
   output logic [CW-1:0]         credits_avail,
   output logic                  idle,
   output logic                  credit_overflow_err
);

   logic [DATA_WIDTH-1:0]    skid_mem_q [2];
   logic                     wr_ptr_q, wr_ptr_d;
   logic                     rd_ptr_q, rd_ptr_d;
   logic [1:0]               skid_cnt_q, skid_cnt_d;
   logic                     ready_q, ready_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [CW:0]              cnt_sum;
   logic                     err_q, err_d;
   logic                     idle_q, idle_d;
   logic [TX_REG_STAGES-1:0] pv_q, pv_d;
   logic [DATA_WIDTH-1:0]    pd_q [TX_REG_STAGES];
   logic                     accept;
   logic                     launch;

   always_comb begin
      accept     = valid_in && ready_q;
      // Launch looks only at the registered count, so a return lands one cycle later.
      launch     = (skid_cnt_q != 2'd0) && (cnt_q != '0);
      wr_ptr_d   = wr_ptr_q ^ accept;
      rd_ptr_d   = rd_ptr_q ^ launch;
      skid_cnt_d = skid_cnt_q + {1'b0, accept} - {1'b0, launch};
      ready_d    = (skid_cnt_d != 2'd2);

      cnt_sum = {1'b0, cnt_q} - (CW+1)'(launch) + {1'b0, credit_return};
      cnt_d   = cnt_sum[CW-1:0];
      err_d   = err_q;
      if (cnt_sum > (CW+1)'(N_CREDITS)) begin
         cnt_d = CW'(N_CREDITS);
         err_d = 1'b1;
      end

      pv_d    = '0;
      pv_d[0] = launch;
      for (int unsigned i = 1; i < TX_REG_STAGES; i++) begin
         pv_d[i] = pv_q[i-1];
      end

      idle_d = (skid_cnt_d == 2'd0) && (pv_d == '0) && (cnt_d == CW'(N_CREDITS));
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q   <= 1'b0;
         rd_ptr_q   <= 1'b0;
         skid_cnt_q <= 2'd0;
         ready_q    <= 1'b0;
         cnt_q      <= CW'(N_CREDITS);
         err_q      <= 1'b0;
         idle_q     <= 1'b1;
         pv_q       <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         skid_cnt_q <= skid_cnt_d;
         ready_q    <= ready_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         idle_q     <= idle_d;
         pv_q       <= pv_d;
      end
   end

   // Payload registers carry no reset; validity is tracked separately above.
   always_ff @(posedge clk) begin
      if (accept) begin
         skid_mem_q[wr_ptr_q] <= data_in;
      end
      pd_q[0] <= skid_mem_q[rd_ptr_q];
      for (int unsigned i = 1; i < TX_REG_STAGES; i++) begin
         pd_q[i] <= pd_q[i-1];
      end
   end

   assign ready_in            = ready_q;
   assign tx_valid            = pv_q[TX_REG_STAGES-1];
   assign tx_data             = pd_q[TX_REG_STAGES-1];
   assign credits_avail       = cnt_q;
   assign idle                = idle_q;
   assign credit_overflow_err = err_q;

endmodule

// File: tb/tb_ofs_plat_axi_mem_if_credit_tx.sv
// Scoreboard bench for the credit transmitter: directed credit scenarios, then
// randomized traffic against a receiver model that returns credits at random.
module tb_ofs_plat_axi_mem_if_credit_tx;

   localparam int unsigned DW = 8;
   localparam int unsigned NC = 16;
   localparam int unsigned ST = 1;
   localparam int unsigned CW = $clog2(NC + 1);

   logic          clk = 1'b0;
   logic          reset_n;
   logic          ready_in;
   logic          valid_in;
   logic [DW-1:0] data_in;
   logic          tx_valid;
   logic [DW-1:0] tx_data;
   logic [CW-1:0] credit_return;
   logic [CW-1:0] credits_avail;
   logic          idle;
   logic          credit_overflow_err;

   always #5 clk = ~clk;

   ofs_plat_axi_mem_if_credit_tx #(
      .DATA_WIDTH   (DW),
      .N_CREDITS    (NC),
      .TX_REG_STAGES(ST)
   ) dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .ready_in           (ready_in),
      .valid_in           (valid_in),
      .data_in            (data_in),
      .tx_valid           (tx_valid),
      .tx_data            (tx_data),
      .credit_return      (credit_return),
      .credits_avail      (credits_avail),
      .idle               (idle),
      .credit_overflow_err(credit_overflow_err)
   );

   int            n_checks = 0;
   int            n_fail   = 0;
   logic [DW-1:0] exp_q [$];
   int            tx_cyc [$];
   int            tx_count = 0;
   int            cyc      = 0;
   int            rx_rcv   = 0;
   int            rx_ret   = 0;
   bit            inv_en   = 1'b0;
   bit            drv_done = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Receiver-side view: every pulse must match the oldest accepted beat.
   // With one output stage, credits + beats held at the receiver + the return
   // currently on the wire always add up to the buffer depth.
   task automatic monitor();
      logic [DW-1:0] e;
      forever begin
         @(negedge clk);
         cyc++;
         if (!reset_n) begin
            exp_q.delete();
         end else begin
            if (tx_valid) begin
               tx_count++;
               tx_cyc.push_back(cyc);
               rx_rcv++;
               if (exp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_beat: got data %0d, expected no beat", tx_data);
               end else begin
                  e = exp_q.pop_front();
                  check("tx_data", int'(tx_data), int'(e));
               end
            end
            if (valid_in && ready_in) exp_q.push_back(data_in);
            if (inv_en)
               check("credit_invariant",
                     int'(credits_avail) + rx_rcv - rx_ret + int'(credit_return), NC);
         end
      end
   endtask

   task automatic push_beat(input logic [DW-1:0] d);
      bit ok;
      ok       = 1'b0;
      valid_in = 1'b1;
      data_in  = d;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         ok = ready_in;
         @(posedge clk);
         #1;
      end
      valid_in = 1'b0;
      check("accept_within_bound", int'(ok), 1);
   endtask

   initial begin
      int n_before;
      int rnd_base;
      bit rcv_ok;

      reset_n       = 1'b0;
      valid_in      = 1'b0;
      data_in       = '0;
      credit_return = '0;

      fork
         monitor();
         begin
            #2_000_000;
            $display("FAIL watchdog: simulation time limit reached");
            $fatal(1, "watchdog");
         end
      join_none

      // Reset values and first cycle after release
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_tx_valid", int'(tx_valid), 0);
      check("rst_ready_in", int'(ready_in), 0);
      check("rst_credits", int'(credits_avail), NC);
      check("rst_overflow_err", int'(credit_overflow_err), 0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("cyc1_ready_in", int'(ready_in), 1);
      check("cyc1_credits", int'(credits_avail), NC);
      check("cyc1_idle", int'(idle), 1);
      check("cyc1_tx_valid", int'(tx_valid), 0);

      // Back-to-back beats with no returns: 16 go out, 2 wait in the skid
      @(posedge clk);
      #1;
      for (int i = 0; i < 18; i++) push_beat(8'(i));
      valid_in = 1'b1;
      data_in  = 8'd18;
      repeat (8) @(negedge clk);
      check("exhaust_tx_count", tx_count, 16);
      check("exhaust_credits", int'(credits_avail), 0);
      check("exhaust_ready_in", int'(ready_in), 0);
      check("exhaust_skid_beats", exp_q.size(), 2);
      check("exhaust_idle", int'(idle), 0);

      // Three credits come back at once: three consecutive launches
      @(posedge clk);
      #1 credit_return = CW'(3);
      @(posedge clk);
      #1 credit_return = '0;
      push_beat(8'd18);
      push_beat(8'd19);
      push_beat(8'd20);
      repeat (4) @(negedge clk);
      check("ret3_tx_count", tx_count, 19);
      check("ret3_consecutive_a", tx_cyc[17] - tx_cyc[16], 1);
      check("ret3_consecutive_b", tx_cyc[18] - tx_cyc[17], 1);
      check("ret3_credits", int'(credits_avail), 0);
      check("ret3_skid_beats", exp_q.size(), 2);

      // Count at 1 with a launch and a return in the same cycle
      @(posedge clk);
      #1 credit_return = CW'(1);
      @(posedge clk);
      #1 credit_return = CW'(1);
      @(posedge clk);
      #1 credit_return = '0;
      @(negedge clk);
      check("cnt1_hold_credits", int'(credits_avail), 1);
      check("cnt1_hold_tx_valid", int'(tx_valid), 1);
      check("cnt1_hold_tx_data", int'(tx_data), 19);
      @(negedge clk);
      check("cnt1_next_credits", int'(credits_avail), 0);
      check("cnt1_next_tx_valid", int'(tx_valid), 1);

      // Return everything, then one extra credit to overflow
      @(posedge clk);
      #1 credit_return = CW'(16);
      @(posedge clk);
      #1 credit_return = '0;
      @(negedge clk);
      check("home_credits", int'(credits_avail), NC);
      check("home_overflow_err", int'(credit_overflow_err), 0);
      check("home_idle", int'(idle), 1);
      @(posedge clk);
      #1 credit_return = CW'(1);
      @(posedge clk);
      #1 credit_return = '0;
      @(negedge clk);
      check("ovf_credits_saturate", int'(credits_avail), NC);
      check("ovf_err_set", int'(credit_overflow_err), 1);
      repeat (5) @(negedge clk);
      check("ovf_err_sticky", int'(credit_overflow_err), 1);

      // Randomized traffic against a randomly returning receiver
      @(posedge clk);
      #1;
      rx_ret   = rx_rcv;
      rnd_base = tx_count;
      inv_en   = 1'b1;
      rcv_ok   = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               if ($urandom_range(0, 3) == 0)
                  repeat ($urandom_range(1, 3)) begin
                     @(posedge clk);
                     #1;
                  end
               push_beat(8'($urandom));
            end
            drv_done = 1'b1;
         end
         begin
            int held;
            int ret;
            for (int c = 0; c < 20000 && !rcv_ok; c++) begin
               @(posedge clk);
               #1;
               held = rx_rcv - rx_ret;
               if (drv_done && exp_q.size() == 0 && held == 0) begin
                  rcv_ok = 1'b1;
               end else begin
                  ret = 0;
                  if (held > 0 && $urandom_range(0, 1) == 1)
                     ret = $urandom_range(1, (held > 3) ? 3 : held);
                  credit_return = CW'(ret);
                  rx_ret += ret;
               end
            end
            credit_return = '0;
         end
      join
      check("rnd_drained_within_bound", int'(rcv_ok), 1);
      @(posedge clk);
      #1 inv_en = 1'b0;
      repeat (3) @(negedge clk);
      check("rnd_beat_count", tx_count - rnd_base, 300);
      check("rnd_credits_home", int'(credits_avail), NC);
      check("rnd_idle", int'(idle), 1);
      check("rnd_ready_in", int'(ready_in), 1);

      // Reset in the middle of a stream
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) push_beat(8'(100 + i));
      check("mid_inflight_before_reset", exp_q.size(), 2);
      #1 reset_n = 1'b0;
      n_before = tx_count;
      #1;
      check("mid_rst_tx_valid", int'(tx_valid), 0);
      check("mid_rst_ready_in", int'(ready_in), 0);
      check("mid_rst_credits", int'(credits_avail), NC);
      check("mid_rst_overflow_err", int'(credit_overflow_err), 0);
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("mid_rel_ready_in", int'(ready_in), 1);
      check("mid_rel_credits", int'(credits_avail), NC);
      check("mid_rel_idle", int'(idle), 1);
      repeat (10) @(negedge clk);
      check("mid_no_stale_beats", tx_count, n_before);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
